// File: rtl/kyber_compress.sv
// kyber_compress: registered Compress_q(x, d) = round(2^D * x / Q) mod 2^D via reciprocal multiply
module kyber_compress #(
    parameter int D = 10,
    parameter int Q = 3329
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [11:0]   in_val,
    output logic [D-1:0]  out_val
);
    localparam int S  = 24;
    localparam int M  = (1 << S) / Q;
    localparam int NW = 13 + D;
    localparam int PW = NW + 13;
    localparam int QW = D + 2;

    generate
        if (!(D == 1 || D == 4 || D == 5 || D == 10 || D == 11)) begin : g_bad_d
            $error("kyber_compress: D must be one of 1, 4, 5, 10, 11");
        end
    endgenerate

    logic [11:0]    x;
    logic [NW-1:0]  num;
    logic [PW-1:0]  prod;
    logic [QW-1:0]  q_est;
    logic [NW-1:0]  rem;

    // M = floor(2^24/Q) underestimates by < 1 for num < 2^24, so q_est is q or q-1
    always_comb begin
        x     = in_val >= 12'(Q) ? in_val - 12'(Q) : in_val;
        num   = (NW'(x) << D) + NW'(Q / 2);
        prod  = PW'(num) * PW'(M);
        q_est = QW'(prod >> S);
        rem   = num - NW'(PW'(q_est) * PW'(Q));
    end

    always_ff @(posedge clk)
        out_val <= rst_n ? D'(q_est + QW'(rem >= NW'(Q))) : '0;
endmodule

// File: tb/tb_kyber_compress.sv
// tb_kyber_compress: scoreboard bench across all legal D against the rounding formula
module tb_kyber_compress;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_val = '0;
    logic [0:0]  o1;
    logic [3:0]  o4;
    logic [4:0]  o5;
    logic [9:0]  o10;
    logic [10:0] o11;

    int ds[5] = '{1, 4, 5, 10, 11};
    int exp_q[5][$];
    int in_q[$];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    kyber_compress #(.D(1))  u1  (.clk(clk), .rst_n(rst_n), .in_val(in_val), .out_val(o1));
    kyber_compress #(.D(4))  u4  (.clk(clk), .rst_n(rst_n), .in_val(in_val), .out_val(o4));
    kyber_compress #(.D(5))  u5  (.clk(clk), .rst_n(rst_n), .in_val(in_val), .out_val(o5));
    kyber_compress #(.D(10)) u10 (.clk(clk), .rst_n(rst_n), .in_val(in_val), .out_val(o10));
    kyber_compress #(.D(11)) u11 (.clk(clk), .rst_n(rst_n), .in_val(in_val), .out_val(o11));

    function automatic int model(int d, int v, bit r);
        int x;
        if (!r) return 0;
        x = v >= 3329 ? v - 3329 : v;
        return (((x << d) + 1664) / 3329) % (1 << d);
    endfunction

    task automatic drive(input bit r, input int v);
        @(negedge clk);
        rst_n  = r;
        in_val = 12'(v);
        in_q.push_back(r ? v : -1);
        for (int k = 0; k < 5; k++) exp_q[k].push_back(model(ds[k], v, r));
    endtask

    function automatic int dut_out(int k);
        case (k)
            0: return int'(o1);
            1: return int'(o4);
            2: return int'(o5);
            3: return int'(o10);
            default: return int'(o11);
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (in_q.size() > 0) begin
                int v;
                v = in_q.pop_front();
                for (int k = 0; k < 5; k++) begin
                    int e, a;
                    e = exp_q[k].pop_front();
                    a = dut_out(k);
                    checks++;
                    if (a == e) passes++;
                    else $display("FAIL d%0d in=%0d got=%0d expected=%0d", ds[k], v, a, e);
                end
            end
        end
    end

    initial begin
        int dir[11] = '{1310, 0, 3328, 3329, 4095, 832, 833, 2496, 2497, 1664, 1310};
        drive(1'b0, 0);
        drive(1'b0, 1310);
        foreach (dir[i]) drive(1'b1, dir[i]);
        drive(1'b0, 4095);
        drive(1'b1, 4095);
        for (int i = 0; i < 4096; i++) drive(i != 2000, i);
        drive(1'b1, 2000);
        repeat (400) drive($urandom_range(0, 19) != 0, int'($urandom_range(0, 4095)));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (in_q.size() == 0) passes++;
        else $display("FAIL drain pending=%0d expected=0", in_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/kyber_compress.md
# kyber_compress

Combinational-plus-register implementation of the ML-KEM/Kyber Compress_q(x, d) function. It maps a 12-bit coefficient in Z_q to a d-bit value: out = round((2^D / Q) · x) mod 2^D. It sits in the ciphertext-encoding datapath after polynomial arithmetic. One instance exists per compression width: D=10 or 11 for vector u, D=4 or 5 for polynomial v, and D=1 for message encoding.

## Interface
Parameters:
- D, default 10, output width in bits; legal values 1, 4, 5, 10, 11 (other values flagged by an elaboration-time check).
- Q, default 3329, modulus; the design is only required to be correct for 3329.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset (one clock; reset is synchronous and active-low).
- in_val, input, 12, coefficient to compress; any 12-bit value is accepted.
- out_val, output, D, compressed coefficient, registered.

## Operation
- Input reduction: x = in_val - Q if in_val ≥ Q, else in_val. A single conditional subtraction suffices because 4095 < 2Q.
- Rounding rule: out = floor((x·2^D + 1664) / 3329) mod 2^D, where 1664 = floor(Q/2).
  - Q is odd, so exact ties never occur.
  - This is identical to round-half-up of x·2^D/Q.
- Wrap: for results equal to 2^D (x near Q), the mod 2^D yields 0. This is required, not saturated.
- No hardware divider. Use constant-reciprocal multiply-and-shift (Barrett style) sized for numerator width 12+D+1 bits. Apply a final ±1 correction so the result is bit-exact against the formula for all 4096 inputs at every legal D.
- Intermediate widths:
  - Numerator x·2^D + 1664: at most 24 bits for D=11.
  - Quotient before the mod: D+1 bits.
  - out_val takes the low D bits.
- No handshake or valid signal. The block samples in_val every cycle.

## Timing
- Latency: exactly 1 clock. out_val after rising edge n reflects in_val sampled at edge n.
- Throughput: one result per clock.
- Reset: while rst_n=0 at a rising edge, out_val ← 0. The reset value of out_val is 0 for every D.
- Reset mid-stream: the in-flight result is discarded and out_val=0 that cycle. The first valid result appears at the first rising edge with rst_n=1.
- Before the first clock edge out_val is undefined. Benches must reset or clock once before checking.
- in_val changes between edges have no effect until the next rising edge. There is no combinational path from in_val to out_val.

## Test plan
- D=10, reset then in_val=1310, wait 1 clock -> out_val=403. D=4 with the same input -> 6.
- D=10: in_val=0 -> 0; in_val=3328 -> 0 (wrap); in_val=3329 -> 0 (reduced to 0).
- D=10: in_val=4095, reduced to 766 -> 236. This verifies the input reduction path.
- D=1 boundaries: 832->0, 833->1, 2496->1, 2497->0, 1664->1. This is the message encoding threshold.
- Exhaustive sweep over in_val 0..4095 for each D in {1,4,5,10,11}, compared against the formula model -> zero mismatches. Also check exactly 1-cycle latency with back-to-back inputs.
- Assert rst_n=0 for one cycle mid-sweep -> out_val=0 on that edge. The next edge after release produces the correct result for the current in_val.
